// File: rtl/riscv_core_pc_gen.sv
// riscv_core_pc_gen
// Registered fetch-PC generator for the RV64I front end.
//
// It owns the fetch PC register and chooses the next PC from three sources:
// back-end redirects (highest priority, index 0 first), a return-address
// stack prediction, and a branch-predictor prediction. If none applies, it
// steps sequentially by INST_BYTES.
//
// Handshake: a PC transfers to fetch ("fire") on a cycle where
// o_pc_gen_fetch_valid and i_pc_gen_fetch_ready are both high. While valid is
// high and ready is low, o_pc_gen_fetch_pc and o_pc_gen_fetch_pred hold
// steady. Valid never drops once it has risen, except on reset.
//
// Optional feature: define RISCV_CORE_PC_GEN_RAS_EN to build the return
// address stack. Without it, push/pop are ignored and the count is 0.
//
// Ports
//   i_clk, i_rst                 clock and synchronous active-high reset
//   i_pc_gen_redirect_valid/addr per-source redirect requests and packed targets
//   i_pc_gen_bp_valid/taken/target  branch prediction for the current fetch PC
//   i_pc_gen_ras_push/pop        call/return markers for the current fetch PC
//   i_pc_gen_fetch_ready         fetch stage accepts the current PC
//   o_pc_gen_fetch_valid/pc/pred current fetch PC, its valid, and predicted flag
//   o_pc_gen_ras_count           number of valid RAS entries
module riscv_core_pc_gen #(
  parameter int                   ADDRLEN      = 64,
  parameter logic [ADDRLEN-1:0]   RESET_ADDR   = 64'h0000_0000_8000_0000,
  parameter int                   NUM_REDIRECT = 2,
  parameter int                   RAS_DEPTH    = 8,
  parameter int                   INST_BYTES   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_REDIRECT-1:0]           i_pc_gen_redirect_valid,
  input  logic [NUM_REDIRECT*ADDRLEN-1:0]   i_pc_gen_redirect_addr,
  input  logic                              i_pc_gen_bp_valid,
  input  logic                              i_pc_gen_bp_taken,
  input  logic [ADDRLEN-1:0]                i_pc_gen_bp_target,
  input  logic                              i_pc_gen_ras_push,
  input  logic                              i_pc_gen_ras_pop,
  input  logic                              i_pc_gen_fetch_ready,
  output logic                              o_pc_gen_fetch_valid,
  output logic [ADDRLEN-1:0]                o_pc_gen_fetch_pc,
  output logic                              o_pc_gen_fetch_pred,
  output logic [$clog2(RAS_DEPTH):0]        o_pc_gen_ras_count
);

  localparam int                 CW  = $clog2(RAS_DEPTH) + 1;
  localparam logic [ADDRLEN-1:0] INC = ADDRLEN'(INST_BYTES);

  // Instructions are at least word aligned here, so the low two bits of
  // every PC load are cleared.
  function automatic logic [ADDRLEN-1:0] align(input logic [ADDRLEN-1:0] a);
    return {a[ADDRLEN-1:2], 2'b00};
  endfunction

  logic                fire;
  logic                redir_any;
  logic [ADDRLEN-1:0]  redir_addr;
  logic [ADDRLEN-1:0]  seq_pc;
  logic                ras_hit;
  logic [ADDRLEN-1:0]  ras_target;
  logic                bp_hit;
  logic [ADDRLEN-1:0]  fire_pc;

  assign fire   = o_pc_gen_fetch_valid & i_pc_gen_fetch_ready;
  assign seq_pc = o_pc_gen_fetch_pc + INC;  // wraps modulo 2^ADDRLEN
  assign bp_hit = i_pc_gen_bp_valid & i_pc_gen_bp_taken;

  // Scan from the highest index down so the lowest active index wins.
  always_comb begin
    redir_any  = 1'b0;
    redir_addr = '0;
    for (int k = NUM_REDIRECT - 1; k >= 0; k--) begin
      if (i_pc_gen_redirect_valid[k]) begin
        redir_any  = 1'b1;
        redir_addr = i_pc_gen_redirect_addr[k*ADDRLEN +: ADDRLEN];
      end
    end
  end

`ifdef RISCV_CORE_PC_GEN_RAS_EN
  localparam int               PW       = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0]    RAS_FULL = CW'(RAS_DEPTH);

  logic [ADDRLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]      ras_top;
  logic [CW-1:0]      ras_count;
  logic               ras_upd;
  logic [PW-1:0]      ras_wr_idx;

  assign ras_hit    = i_pc_gen_ras_pop & (ras_count != '0);
  assign ras_target = ras_mem[ras_top];
  assign ras_upd    = fire & ~redir_any;
  // Push+pop replaces the top entry in place; push alone writes above it.
  assign ras_wr_idx = ras_hit ? ras_top : ras_top + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst || redir_any) begin
      ras_top   <= '0;
      ras_count <= '0;
    end else if (ras_upd) begin
      if (i_pc_gen_ras_push && !ras_hit) begin
        ras_top <= ras_top + 1'b1;
        // When full, the oldest entry is silently overwritten.
        if (ras_count != RAS_FULL) ras_count <= ras_count + 1'b1;
      end else if (ras_hit && !i_pc_gen_ras_push) begin
        ras_top   <= ras_top - 1'b1;
        ras_count <= ras_count - 1'b1;
      end
    end
  end

  // Contents need no reset; only the pointer and count define validity.
  always_ff @(posedge i_clk) begin
    if (!i_rst && ras_upd && i_pc_gen_ras_push) ras_mem[ras_wr_idx] <= seq_pc;
  end

  assign o_pc_gen_ras_count = ras_count;
`else
  logic unused_ras;
  assign unused_ras         = i_pc_gen_ras_push ^ i_pc_gen_ras_pop;
  assign ras_hit            = 1'b0;
  assign ras_target         = '0;
  assign o_pc_gen_ras_count = '0;
`endif

  always_comb begin
    fire_pc = seq_pc;
    if (ras_hit)     fire_pc = ras_target;
    else if (bp_hit) fire_pc = i_pc_gen_bp_target;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc_gen_fetch_pc    <= align(RESET_ADDR);
      o_pc_gen_fetch_valid <= 1'b0;
      o_pc_gen_fetch_pred  <= 1'b0;
    end else if (redir_any) begin
      o_pc_gen_fetch_pc    <= align(redir_addr);
      o_pc_gen_fetch_valid <= 1'b1;
      o_pc_gen_fetch_pred  <= 1'b0;
    end else if (fire) begin
      o_pc_gen_fetch_pc    <= align(fire_pc);
      o_pc_gen_fetch_pred  <= ras_hit | bp_hit;
    end else if (!o_pc_gen_fetch_valid) begin
      // One bubble after reset release, then RESET_ADDR is offered.
      o_pc_gen_fetch_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_core_pc_gen.sv
module tb_riscv_core_pc_gen;

  localparam int          ADDRLEN      = 64;
  localparam int          NUM_REDIRECT = 2;
  localparam int          RAS_DEPTH    = 8;
  localparam int          CW           = $clog2(RAS_DEPTH) + 1;
  localparam int          W            = 2 + CW + ADDRLEN;
  localparam logic [63:0] RESET_ADDR   = 64'h0000_0000_8000_0000;

  logic                            clk;
  logic                            rst;
  logic [NUM_REDIRECT-1:0]         redirect_valid;
  logic [NUM_REDIRECT*ADDRLEN-1:0] redirect_addr;
  logic                            bp_valid;
  logic                            bp_taken;
  logic [ADDRLEN-1:0]              bp_target;
  logic                            ras_push;
  logic                            ras_pop;
  logic                            fetch_ready;
  logic                            fetch_valid;
  logic [ADDRLEN-1:0]              fetch_pc;
  logic                            fetch_pred;
  logic [CW-1:0]                   ras_count;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp;
  int           n_fail;

  riscv_core_pc_gen #(
    .ADDRLEN(ADDRLEN), .RESET_ADDR(RESET_ADDR), .NUM_REDIRECT(NUM_REDIRECT),
    .RAS_DEPTH(RAS_DEPTH), .INST_BYTES(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_pc_gen_redirect_valid(redirect_valid),
    .i_pc_gen_redirect_addr(redirect_addr),
    .i_pc_gen_bp_valid(bp_valid),
    .i_pc_gen_bp_taken(bp_taken),
    .i_pc_gen_bp_target(bp_target),
    .i_pc_gen_ras_push(ras_push),
    .i_pc_gen_ras_pop(ras_pop),
    .i_pc_gen_fetch_ready(fetch_ready),
    .o_pc_gen_fetch_valid(fetch_valid),
    .o_pc_gen_fetch_pc(fetch_pc),
    .o_pc_gen_fetch_pred(fetch_pred),
    .o_pc_gen_ras_count(ras_count)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic idle();
    redirect_valid = '0;
    redirect_addr  = '0;
    bp_valid       = 1'b0;
    bp_taken       = 1'b0;
    bp_target      = '0;
    ras_push       = 1'b0;
    ras_pop        = 1'b0;
    fetch_ready    = 1'b0;
  endtask

  task automatic bp(input logic [63:0] tgt);
    bp_valid  = 1'b1;
    bp_taken  = 1'b1;
    bp_target = tgt;
  endtask

  // Scoreboard
  task automatic expect_out(input string tag, input logic v, input logic p,
                            input logic [CW-1:0] c, input logic [63:0] pc);
    exp_q.push_back({v, p, c, pc});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    string        tag;
    obs = {fetch_valid, fetch_pred, ras_count, fetch_pc};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed pc=%h expected a queued entry", fetch_pc);
      return;
    end
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed v=%b p=%b cnt=%0d pc=%h expected v=%b p=%b cnt=%0d pc=%h",
             tag, obs[W-1], obs[W-2], obs[ADDRLEN +: CW], obs[ADDRLEN-1:0],
             exp[W-1], exp[W-2], exp[ADDRLEN +: CW], exp[ADDRLEN-1:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic redirect_to(input string tag, input logic [63:0] a);
    idle();
    redirect_valid = 2'b01;
    redirect_addr[63:0] = a;
    expect_out(tag, 1'b1, 1'b0, '0, {a[63:2], 2'b00});
    step();
    idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle();
    rst = 1'b1;

    // Reset state
    expect_out("reset_state", 1'b0, 1'b0, '0, RESET_ADDR);
    step();
    expect_out("reset_hold", 1'b0, 1'b0, '0, RESET_ADDR);
    step();

    // Bubble then sequential fetch
    rst = 1'b0;
    fetch_ready = 1'b1;
    expect_out("post_reset_valid", 1'b1, 1'b0, '0, 64'h8000_0000);
    step();
    expect_out("seq_4", 1'b1, 1'b0, '0, 64'h8000_0004);
    step();
    expect_out("seq_8", 1'b1, 1'b0, '0, 64'h8000_0008);
    step();

    // Redirect priority while stalled
    idle();
    redirect_valid = 2'b11;
    redirect_addr  = {64'h200, 64'h100};
    expect_out("redir_prio", 1'b1, 1'b0, '0, 64'h100);
    step();
    redirect_valid = 2'b10;
    redirect_addr  = {64'h203, 64'h100};
    expect_out("redir_src1_align", 1'b1, 1'b0, '0, 64'h200);
    step();
    idle();
    bp(64'h7000);
    expect_out("stall_hold", 1'b1, 1'b0, '0, 64'h200);
    step();

    // Branch prediction
    redirect_to("redir_1000", 64'h1000);
    fetch_ready = 1'b1;
    bp(64'h2003);
    expect_out("bp_taken", 1'b1, 1'b1, '0, 64'h2000);
    step();
    fetch_ready = 1'b0;
    bp(64'h3000);
    expect_out("bp_stall_hold", 1'b1, 1'b1, '0, 64'h2000);
    step();
    bp(64'h4000);
    expect_out("bp_stall_hold2", 1'b1, 1'b1, '0, 64'h2000);
    step();
    fetch_ready = 1'b1;
    bp_valid = 1'b0;
    expect_out("bp_invalid_seq", 1'b1, 1'b0, '0, 64'h2004);
    step();
    bp_valid = 1'b1;
    bp_taken = 1'b0;
    expect_out("bp_not_taken_seq", 1'b1, 1'b0, '0, 64'h2008);
    step();

    // Redirect beats a firing prediction
    idle();
    fetch_ready = 1'b1;
    bp(64'h9000);
    redirect_valid = 2'b10;
    redirect_addr  = {64'h4440, 64'h0};
    expect_out("redir_beats_fire", 1'b1, 1'b0, '0, 64'h4440);
    step();

`ifndef RISCV_CORE_PC_GEN_RAS_EN
    idle();
    fetch_ready = 1'b1;
    ras_push = 1'b1;
    expect_out("ras_push_ignored", 1'b1, 1'b0, '0, 64'h4444);
    step();
    ras_push = 1'b0;
    ras_pop  = 1'b1;
    expect_out("ras_pop_ignored", 1'b1, 1'b0, '0, 64'h4448);
    step();
`endif

    // Wraparound
    redirect_to("redir_top", 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_ready = 1'b1;
    expect_out("wrap_zero", 1'b1, 1'b0, '0, 64'h0);
    step();

`ifdef RISCV_CORE_PC_GEN_RAS_EN
    redirect_to("ras_redir_1000", 64'h1000);
    fetch_ready = 1'b1;
    ras_push = 1'b1;
    bp(64'h3000);
    expect_out("ras_push1", 1'b1, 1'b1, 4'd1, 64'h3000);
    step();
    bp(64'h5000);
    expect_out("ras_push2", 1'b1, 1'b1, 4'd2, 64'h5000);
    step();
    idle();
    fetch_ready = 1'b1;
    ras_pop = 1'b1;
    expect_out("ras_pop1", 1'b1, 1'b1, 4'd1, 64'h3004);
    step();
    expect_out("ras_pop2", 1'b1, 1'b1, 4'd0, 64'h1004);
    step();
    bp(64'h500);
    expect_out("ras_pop_empty_bp", 1'b1, 1'b1, 4'd0, 64'h500);
    step();
    idle();
    fetch_ready = 1'b1;
    ras_push = 1'b1;
    expect_out("ras_push_seq", 1'b1, 1'b0, 4'd1, 64'h504);
    step();
    idle();
    fetch_ready = 1'b1;
    ras_push = 1'b1;
    redirect_valid = 2'b01;
    redirect_addr  = {64'h0, 64'h500};
    expect_out("ras_flush", 1'b1, 1'b0, 4'd0, 64'h500);
    step();
    idle();
    fetch_ready = 1'b1;
    ras_push = 1'b1;
    for (int i = 0; i < 9; i++) begin
      expect_out($sformatf("ras_fill_%0d", i), 1'b1, 1'b0,
                 CW'((i + 1 > RAS_DEPTH) ? RAS_DEPTH : i + 1), 64'h504 + 64'(4 * i));
      step();
    end
    ras_pop = 1'b1;
    expect_out("ras_push_pop", 1'b1, 1'b1, 4'd8, 64'h524);
    step();
    ras_push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("ras_drain_%0d", i), 1'b1, 1'b1, CW'(7 - i),
                 (i == 0) ? 64'h528 : 64'h524 - 64'(4 * i));
      step();
    end
`endif

    // Reset wins over a redirect mid-stall
    idle();
    rst = 1'b1;
    redirect_valid = 2'b01;
    redirect_addr  = {64'h0, 64'h1230};
    expect_out("reset_over_redirect", 1'b0, 1'b0, '0, RESET_ADDR);
    step();
    idle();
    rst = 1'b0;
    expect_out("reset_release_bubble", 1'b1, 1'b0, '0, RESET_ADDR);
    step();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_pc_gen.md
# riscv_core_pc_gen

Registered program-counter generator for the RV64I front end, successor to the purely combinational next-PC select. It owns the fetch PC register, arbitrates a parametrised number of prioritised redirect sources against branch-predictor and return-address-stack (RAS) predictions, and presents the PC to the fetch stage over a valid/ready handshake. It sits between the back-end recovery and commit paths and the I-cache request port.

## Interface
- ADDRLEN, 64, PC width in bits
- RESET_ADDR, 64'h0000_0000_8000_0000, PC loaded by reset (bits [1:0] must be 0)
- NUM_REDIRECT, 2, number of redirect sources; index 0 highest priority
- RAS_DEPTH, 8, RAS entries (power of two, ≥2)
- INST_BYTES, 4, sequential PC increment

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_pc_gen_redirect_valid  in  NUM_REDIRECT  per-source redirect request
- i_pc_gen_redirect_addr  in  NUM_REDIRECT*ADDRLEN  packed targets; source k at [k*ADDRLEN +: ADDRLEN]
- i_pc_gen_bp_valid  in  1  predictor output valid for current o_pc_gen_fetch_pc
- i_pc_gen_bp_taken  in  1  predicted taken
- i_pc_gen_bp_target  in  ADDRLEN  predicted target
- i_pc_gen_ras_push  in  1  current fetch PC is a call; push PC+INST_BYTES
- i_pc_gen_ras_pop  in  1  current fetch PC is a return; use RAS top as target
- i_pc_gen_fetch_ready  in  1  fetch stage accepts current PC
- o_pc_gen_fetch_valid  out  1  o_pc_gen_fetch_pc is valid
- o_pc_gen_fetch_pc  out  ADDRLEN  current fetch PC
- o_pc_gen_fetch_pred  out  1  current PC was produced by a taken BP or RAS prediction
- o_pc_gen_ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- Fire = o_pc_gen_fetch_valid & i_pc_gen_fetch_ready.
- Next-state priority, evaluated every cycle:
  1. i_rst: PC←RESET_ADDR, fetch_valid←0, fetch_pred←0, RAS count←0.
  2. Any redirect_valid: PC←addr of lowest active index; fetch_valid←1; fetch_pred←0; RAS count←0 (flush). Applies regardless of fire; BP/RAS inputs ignored.
  3. Fire: PC← RAS top if ras_pop & count>0; else bp_target if bp_valid & bp_taken; else PC+INST_BYTES. fetch_pred←1 for the first two cases, else 0. RAS updated per below.
  4. Otherwise: hold all state; BP/RAS inputs ignored.
- After reset release, fetch_valid rises on the following edge (one bubble cycle) with PC=RESET_ADDR.
- Bits [1:0] of every value loaded into PC forced to 0; addition wraps modulo 2^ADDRLEN.
- RAS (only on fire, no redirect): circular buffer with top pointer.
  - Push only: write PC+INST_BYTES at top+1, top advances; count saturates at RAS_DEPTH (oldest entry overwritten).
  - Pop only, count>0: target = top entry; top retreats; count−1.
  - Pop with count==0: no RAS action; falls through to BP/sequential.
  - Push and pop together: target = old top entry; top entry overwritten with PC+INST_BYTES; count unchanged (count 0: push only, target from BP/sequential).

## Timing
- One-cycle latency: inputs at cycle t visible on o_pc_gen_fetch_pc at t+1.
- Redirect asserted at t ⇒ o_pc_gen_fetch_pc = target, fetch_valid=1 at t+1, even if fetch was stalled.
- While fetch_valid & !fetch_ready, fetch_pc and fetch_pred stable.
- BP and RAS inputs are combinational functions of current o_pc_gen_fetch_pc, sampled only on fire.
- Reset values: o_pc_gen_fetch_valid=0, o_pc_gen_fetch_pc=RESET_ADDR, o_pc_gen_fetch_pred=0, o_pc_gen_ras_count=0.
- Reset mid-stall or during redirect: reset wins; RAS contents need not be cleared, only count/pointer.

## Configuration
- RISCV_CORE_PC_GEN_RAS_EN defined: RAS storage and logic built as above.
- Not defined: no RAS storage; i_pc_gen_ras_push/pop ignored; o_pc_gen_ras_count tied 0; next PC on fire is BP target or sequential only.

## Test plan
- Reset then ready=1, no BP: fetch_pc sequence 0x8000_0000 (valid from second post-reset cycle), 0x8000_0004, 0x8000_0008.
- Redirects 0 and 1 both valid, addr0=0x100, addr1=0x200, ready=0: next cycle fetch_pc=0x100, valid=1, pred=0, ras_count=0.
- Fire at PC 0x1000 with bp_valid=1, taken=1, target=0x2003: next fetch_pc=0x2000, pred=1; with ready=0 and BP changing, PC holds.
- RAS_EN: push at 0x1000, push at 0x3000, pop, pop: targets 0x3004 then 0x1004, count 1,2,1,0; pop on empty with bp taken 0x500 ⇒ 0x500.
- RAS_EN, RAS_DEPTH=8: 9 pushes ⇒ count 8; 8 pops return latest 8 addresses LIFO; simultaneous push+pop returns old top, count unchanged.
- Fire at 0xFFFF_FFFF_FFFF_FFFC sequential ⇒ PC wraps to 0x0.
